// File: rtl/weight_fifo_in_ctrl.sv
// Weight FIFO fill controller: fetches one tile of rows from SRAM, pushes them into the column FIFOs,
// then kicks and waits for the output controller. Optional zero padding: WFIFO_IN_ZERO_PAD_EN.

module weight_fifo_in_ctrl_chk (
  input logic clk,
  input logic rstn,
  input logic i_stray
);
  // A response nobody asked for is dropped by the controller; surface it in simulation.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rstn) !i_stray)
    else $warning("weight_fifo_in_ctrl: unexpected mem_rsp_valid dropped");
endmodule

module weight_fifo_in_ctrl #(
  parameter int FIFO_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int ADDR_STRIDE     = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
`ifdef WFIFO_IN_ZERO_PAD_EN
  input  logic [$clog2(FIFO_DEPTH):0]      i_num_rows,
`endif
  output logic                             o_mem_req_valid,
  input  logic                             i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]            o_mem_req_addr,
  input  logic                             i_mem_rsp_valid,
  input  logic [FIFO_WIDTH*DATA_WIDTH-1:0] i_mem_rsp_data,
  output logic [FIFO_WIDTH-1:0]            o_fifo_push,
  output logic [FIFO_WIDTH*DATA_WIDTH-1:0] o_fifo_wdata,
  output logic                             o_drain_en,
  input  logic                             i_drain_done,
  output logic                             o_busy,
  output logic                             o_tile_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_KICK, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_req_cnt;
  logic [CW-1:0]         r_rsp_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_drain_en;
  logic                  r_busy;
  logic                  r_tile_done;

  logic [CW-1:0] w_rows;
  logic [CW-1:0] w_pushed;
  logic [CW-1:0] w_outstanding;
  logic          w_fetch;
  logic          w_req_valid;
  logic          w_req_acc;
  logic          w_rsp_acc;
  logic          w_pad_push;

`ifdef WFIFO_IN_ZERO_PAD_EN
  logic [CW-1:0] r_rows;
  logic [CW-1:0] r_pad_cnt;
  logic [CW-1:0] w_rows_in;

  // Requests beyond the tile depth make no sense, so oversized row counts are clamped.
  assign w_rows_in  = (i_num_rows > DEPTH_C) ? DEPTH_C : i_num_rows;
  assign w_rows     = r_rows;
  assign w_pushed   = r_rsp_cnt + r_pad_cnt;
  assign w_pad_push = w_fetch && (r_rsp_cnt == r_rows) && (w_pushed < DEPTH_C);
`else
  assign w_rows     = DEPTH_C;
  assign w_pushed   = r_rsp_cnt;
  assign w_pad_push = 1'b0;
`endif

  assign w_outstanding = r_req_cnt - r_rsp_cnt;
  assign w_fetch       = (r_state == S_FETCH);
  assign w_req_valid   = w_fetch && (r_req_cnt < w_rows) &&
                         (32'(w_outstanding) < 32'(MAX_OUTSTANDING));
  assign w_req_acc     = w_req_valid && i_mem_req_ready;
  // Only responses to issued requests are accepted; anything else is dropped.
  assign w_rsp_acc     = w_fetch && i_mem_rsp_valid && (r_rsp_cnt != r_req_cnt);

  assign o_mem_req_valid = w_req_valid;
  assign o_mem_req_addr  = r_addr;
  assign o_fifo_push     = {FIFO_WIDTH{w_rsp_acc || w_pad_push}};
  assign o_fifo_wdata    = w_rsp_acc ? i_mem_rsp_data : {(FIFO_WIDTH*DATA_WIDTH){1'b0}};
  assign o_drain_en      = r_drain_en;
  assign o_busy          = r_busy;
  assign o_tile_done     = r_tile_done;

  // Tile sequencing, request/response bookkeeping and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_req_cnt   <= {CW{1'b0}};
      r_rsp_cnt   <= {CW{1'b0}};
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_drain_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_tile_done <= 1'b0;
`ifdef WFIFO_IN_ZERO_PAD_EN
      r_rows      <= {CW{1'b0}};
      r_pad_cnt   <= {CW{1'b0}};
`endif
    end else begin
      r_drain_en  <= 1'b0;
      r_tile_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr    <= i_base_addr;
            r_req_cnt <= {CW{1'b0}};
            r_rsp_cnt <= {CW{1'b0}};
`ifdef WFIFO_IN_ZERO_PAD_EN
            r_rows    <= w_rows_in;
            r_pad_cnt <= {CW{1'b0}};
`endif
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_req_acc) begin
            r_req_cnt <= r_req_cnt + {{(CW-1){1'b0}}, 1'b1};
            r_addr    <= r_addr + ADDR_WIDTH'(ADDR_STRIDE);
          end
          if (w_rsp_acc) begin
            r_rsp_cnt <= r_rsp_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
`ifdef WFIFO_IN_ZERO_PAD_EN
          if (w_pad_push) begin
            r_pad_cnt <= r_pad_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
`endif
          // Leave one cycle after the final push so the FIFOs settle before the kick.
          if (w_pushed == DEPTH_C) begin
            r_drain_en <= 1'b1;
            r_state    <= S_KICK;
          end
        end
        S_KICK: begin
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (i_drain_done) begin
            r_tile_done <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  weight_fifo_in_ctrl_chk u_chk (
    .clk     (clk),
    .rstn    (rstn),
    .i_stray (i_mem_rsp_valid && !w_rsp_acc)
  );

endmodule
